// File: rtl/fetch_seq_pkg.sv
// -----------------------------------------------------------------------------
// fetch_seq_pkg
// Shared definitions for the fetch sequencer: FSM state encoding, instruction
// size, default reset/trap vectors and the redirect-target helper.
// -----------------------------------------------------------------------------
package fetch_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_ISSUE  = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_t;

    localparam logic [31:0] INSN_BYTES           = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

    // PC to load on a redirect. With trapping enabled a misaligned target
    // is replaced by the trap vector; otherwise the target is word-aligned
    // by clearing its low two bits.
    function automatic logic [31:0] redirect_pc(input logic [31:0] target,
                                                input logic [31:0] trap_vec,
                                                input logic        trap_en);
        logic [31:0] result;
        if (trap_en && (target[1:0] != 2'b00)) begin
            result = trap_vec;
        end else begin
            result = {target[31:2], 2'b00};
        end
        return result;
    endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Sequences the CPU program counter and the instruction-memory fetch.
// next_pc is loaded by the external program_counter register every cycle.
// A request/ack fetch fills a registered instruction slot that is handed to
// decode with a valid/ready handshake. Execute redirects and a halt level
// are honoured (priority: rst > redirect > halt > normal flow).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   pc                current program_counter value
//   next_pc           value program_counter loads at the next edge
//   imem_req/addr     fetch request and address (combinational)
//   imem_ack/rdata    fetch completion and instruction word
//   inst/inst_valid   registered instruction to decode
//   inst_ready        decode accepts inst
//   redirect_valid    branch/jump taken pulse, redirect_target = new PC
//   halt              level, stop fetching
//   trap/trap_addr    misaligned-redirect pulse and offending target
//
// Configuration macro: FETCH_MISALIGN_TRAP_EN
//   defined   : misaligned redirect goes to TRAP_VECTOR, trap pulses and
//               trap_addr captures the target
//   undefined : target low bits forced to zero, trap/trap_addr tied to 0
// -----------------------------------------------------------------------------
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic [31:0] next_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        halt,
    output logic        trap,
    output logic [31:0] trap_addr
);

`ifdef FETCH_MISALIGN_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    fetch_state_t state_r;
    fetch_state_t state_nxt_s;
    logic [31:0]  inst_r;
    logic         inst_valid_r;
    logic         load_inst_s;
    logic [31:0]  redirect_pc_s;

    assign redirect_pc_s = redirect_pc(redirect_target, TRAP_VECTOR, TRAP_EN);

    // Next-state and next-PC selection; a redirect overrides everything but
    // reset and also discards any same-cycle fetch completion.
    always_comb begin
        state_nxt_s = state_r;
        next_pc     = pc;
        load_inst_s = 1'b0;
        if (rst) begin
            state_nxt_s = ST_IDLE;
            next_pc     = RESET_VECTOR;
        end else if (redirect_valid) begin
            next_pc     = redirect_pc_s;
            state_nxt_s = (state_r == ST_HALTED) ? ST_HALTED : ST_FETCH;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    next_pc     = RESET_VECTOR;
                    state_nxt_s = halt ? ST_HALTED : ST_FETCH;
                end
                ST_FETCH: begin
                    // halt is not checked here: the outstanding fetch finishes
                    if (imem_ack) begin
                        load_inst_s = 1'b1;
                        state_nxt_s = ST_ISSUE;
                    end else begin
                        state_nxt_s = ST_FETCH;
                    end
                end
                ST_ISSUE: begin
                    if (inst_ready) begin
                        next_pc     = pc + INSN_BYTES;
                        state_nxt_s = halt ? ST_HALTED : ST_FETCH;
                    end else begin
                        state_nxt_s = ST_ISSUE;
                    end
                end
                ST_HALTED: begin
                    state_nxt_s = halt ? ST_HALTED : ST_FETCH;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    next_pc     = RESET_VECTOR;
                end
            endcase
        end
    end

    // State register plus the instruction slot handed to decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            inst_r       <= 32'h0000_0000;
            inst_valid_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            inst_r       <= load_inst_s ? imem_rdata : inst_r;
            inst_valid_r <= (state_nxt_s == ST_ISSUE);
        end
    end

    assign imem_req   = (state_r == ST_FETCH);
    assign imem_addr  = imem_req ? pc : 32'h0000_0000;
    assign inst       = inst_r;
    assign inst_valid = inst_valid_r;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic        trap_r;
    logic [31:0] trap_addr_r;
    logic        misalign_s;

    assign misalign_s = redirect_valid && (redirect_target[1:0] != 2'b00);

    // One-cycle trap pulse; trap_addr holds until the next trap or reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            trap_r      <= 1'b0;
            trap_addr_r <= 32'h0000_0000;
        end else begin
            trap_r      <= misalign_s;
            trap_addr_r <= misalign_s ? redirect_target : trap_addr_r;
        end
    end

    assign trap      = trap_r;
    assign trap_addr = trap_addr_r;
`else
    assign trap      = 1'b0;
    assign trap_addr = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
// Directed bench for fetch_sequencer. The bench models program_counter
// (pc <= next_pc every edge) and an instruction memory whose word is either
// a forced value or imem_addr ^ 32'hC0DE_0000.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt;
    logic        trap;
    logic [31:0] trap_addr;

    logic        force_rdata;
    logic [31:0] forced_word;

    int pass_cnt  = 0;
    int total_cnt = 0;

    fetch_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .pc              (pc),
        .next_pc         (next_pc),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .inst            (inst),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt            (halt),
        .trap            (trap),
        .trap_addr       (trap_addr)
    );

    always #5 clk = ~clk;

    // program_counter model
    always @(posedge clk) pc <= next_pc;

    assign imem_rdata = force_rdata ? forced_word : (imem_addr ^ 32'hC0DE_0000);

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1; imem_ack = 1'b1; inst_ready = 1'b1; halt = 1'b0;
        redirect_valid = 1'b0; redirect_target = 32'h0; force_rdata = 1'b0;
        forced_word = 32'h0;
        #1;
        check("rst_next_pc", next_pc, 32'h0);

        // ---- reset and straight-line fetch ----
        tick();
        rst = 1'b0;
        #1;
        check("idle_req", {31'h0, imem_req}, 32'h0);
        check("idle_addr", imem_addr, 32'h0);
        check("idle_inst", inst, 32'h0);
        check("idle_valid", {31'h0, inst_valid}, 32'h0);
        check("idle_trap", {31'h0, trap}, 32'h0);
        check("idle_trap_addr", trap_addr, 32'h0);
        check("idle_next_pc", next_pc, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("seq_req", {31'h0, imem_req}, 32'h1);
            check("seq_addr", imem_addr, 32'(i * 4));
            check("seq_valid_lo", {31'h0, inst_valid}, 32'h0);
            tick();
            check("seq_valid_hi", {31'h0, inst_valid}, 32'h1);
            check("seq_inst", inst, 32'(i * 4) ^ 32'hC0DE_0000);
            check("seq_next_pc", next_pc, 32'(i * 4 + 4));
        end

        // ---- backpressure ----
        rst = 1'b1;
        tick();
        rst = 1'b0; inst_ready = 1'b0; force_rdata = 1'b1; forced_word = 32'hDEAD_BEEF;
        tick();
        check("bp_fetch_addr", imem_addr, 32'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            check("bp_inst", inst, 32'hDEAD_BEEF);
            check("bp_valid", {31'h0, inst_valid}, 32'h1);
            check("bp_no_req", {31'h0, imem_req}, 32'h0);
            check("bp_pc", pc, 32'h0);
            check("bp_next_pc", next_pc, 32'h0);
        end
        inst_ready = 1'b1;
        #1;
        check("bp_ready_next_pc", next_pc, 32'h4);
        tick();
        check("bp_pc_adv", pc, 32'h4);
        check("bp_addr_adv", imem_addr, 32'h4);
        check("bp_valid_drop", {31'h0, inst_valid}, 32'h0);
        force_rdata = 1'b0;

        // ---- redirect during ISSUE ----
        tick();
        check("rd_issue_inst", inst, 32'hC0DE_0004);
        inst_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h0000_0040;
        #1;
        check("rd_next_pc", next_pc, 32'h40);
        tick();
        redirect_valid = 1'b0;
        check("rd_valid_drop", {31'h0, inst_valid}, 32'h0);
        check("rd_addr", imem_addr, 32'h40);
        check("rd_req", {31'h0, imem_req}, 32'h1);

        // ---- redirect in FETCH with same-cycle ack, to the wrap point ----
        inst_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
        #1;
        check("wrap_rd_next_pc", next_pc, 32'hFFFF_FFFC);
        tick();
        redirect_valid = 1'b0;
        check("ack_discard_valid", {31'h0, inst_valid}, 32'h0);
        check("ack_discard_inst", inst, 32'hC0DE_0004);
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        check("wrap_inst", inst, 32'h3F21_FFFC);
        check("wrap_next_pc", next_pc, 32'h0);
        tick();
        check("wrap_addr0", imem_addr, 32'h0);
        check("wrap_req", {31'h0, imem_req}, 32'h1);

        // ---- halt raised in FETCH ----
        imem_ack = 1'b0; halt = 1'b1;
        tick();
        check("halt_fetch_req", {31'h0, imem_req}, 32'h1);
        imem_ack = 1'b1;
        tick();
        check("halt_issue_valid", {31'h0, inst_valid}, 32'h1);
        check("halt_issue_inst", inst, 32'hC0DE_0000);
        check("halt_issue_next_pc", next_pc, 32'h4);
        tick();
        check("halted_req", {31'h0, imem_req}, 32'h0);
        check("halted_valid", {31'h0, inst_valid}, 32'h0);
        check("halted_next_pc", next_pc, 32'h4);
        tick();
        check("halted_req2", {31'h0, imem_req}, 32'h0);
        halt = 1'b0;
        #1;
        check("unhalt_same_cycle", {31'h0, imem_req}, 32'h0);
        tick();
        check("unhalt_req", {31'h0, imem_req}, 32'h1);
        check("unhalt_addr", imem_addr, 32'h4);

        // ---- misaligned redirect ----
        redirect_valid = 1'b1; redirect_target = 32'h0000_0022;
        #1;
`ifdef FETCH_MISALIGN_TRAP_EN
        check("mis_next_pc", next_pc, 32'h100);
`else
        check("mis_next_pc", next_pc, 32'h20);
`endif
        tick();
        redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        check("mis_addr", imem_addr, 32'h100);
        check("mis_trap", {31'h0, trap}, 32'h1);
        check("mis_trap_addr", trap_addr, 32'h22);
`else
        check("mis_addr", imem_addr, 32'h20);
        check("mis_trap", {31'h0, trap}, 32'h0);
        check("mis_trap_addr", trap_addr, 32'h0);
`endif
        tick();
        check("mis_trap_pulse_end", {31'h0, trap}, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("mis_trap_addr_hold", trap_addr, 32'h22);
`else
        check("mis_trap_addr_hold", trap_addr, 32'h0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
